// File: rtl/local_event_fifo_pkg.sv
// Shared definitions for the per-channel local event FIFO.
// Holds the default geometry, the stored event-word type and the pointer width.
package local_event_fifo_pkg;

    // Event word width including parity; the stored word drops the parity bit.
    localparam int LEF_WIDTH = 64;

    // Entries per channel FIFO (power of two, 2..16).
    localparam int LEF_DEPTH = 4;

    // Read/write pointer width for the default depth.
    localparam int LEF_PTR_W = $clog2(LEF_DEPTH);

    // Stored (pre-parity) event word.
    typedef logic [LEF_WIDTH-2:0] event_word_t;

endpackage

// File: rtl/local_fifo_mem.sv
// Storage array for local_event_fifo: one synchronous write port and one
// asynchronous read port. Contents are not reset; the FIFO's empty flag
// masks whatever the array holds after reset.
module local_fifo_mem #(
    parameter int DW    = 63,
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [PW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [DEPTH];

    // Write the accepted event word into the tail slot.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/local_event_fifo.sv
// Per-channel first-word-fall-through event FIFO feeding the event router.
// Circular buffer with registered pointers, occupancy count and flags.
// Optional feature: define LOCAL_FIFO_OVERFLOW_COUNT_EN to add the
// saturating overflow_count port counting dropped writes.
module local_event_fifo
    import local_event_fifo_pkg::*;
#(
    parameter int WIDTH = LEF_WIDTH,
    parameter int DEPTH = LEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-2:0]         write_data,
    input  logic                     write_req,
    input  logic                     read_local_fifo_n,
    output logic [WIDTH-2:0]         local_event_out,
    output logic                     local_fifo_empty,
    output logic                     local_fifo_full,
    output logic [$clog2(DEPTH):0]   fifo_count
`ifdef LOCAL_FIFO_OVERFLOW_COUNT_EN
    ,
    output logic [7:0]               overflow_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;
    logic             empty_r;
    logic             full_r;
    logic             pop_s;
    logic             wr_s;
    logic [WIDTH-2:0] head_s;

    // Advance a pointer, wrapping from DEPTH-1 back to 0.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1'b1);
    endfunction

    // A pop needs stored data; a write needs room, or a same-edge pop freeing a slot.
    assign pop_s = ~read_local_fifo_n & ~empty_r;
    assign wr_s  = write_req & (~full_r | pop_s);

    local_fifo_mem #(
        .DW    (WIDTH - 1),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_s),
        .waddr (wr_ptr_r),
        .wdata (write_data),
        .raddr (rd_ptr_r),
        .rdata (head_s)
    );

    // Next occupancy: write and pop on the same edge cancel out.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1'b1);
            2'b01:   count_nxt_s = count_r - CW'(1'b1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, count and flags; reset wins over any same-edge write or pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            count_r <= count_nxt_s;
            empty_r <= (count_nxt_s == {CW{1'b0}});
            full_r  <= (count_nxt_s == CW'(DEPTH));
        end
    end

`ifdef LOCAL_FIFO_OVERFLOW_COUNT_EN
    logic [7:0] overflow_r;

    // Count writes dropped because the FIFO was full with no pop; saturate at 255.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_r <= 8'd0;
        end else if (write_req && full_r && !pop_s && (overflow_r != 8'd255)) begin
            overflow_r <= overflow_r + 8'd1;
        end
    end

    assign overflow_count = overflow_r;
`endif

    // Head word falls through while data is stored; zero when empty or in reset.
    assign local_event_out  = (empty_r || reset) ? {(WIDTH-1){1'b0}} : head_s;
    assign local_fifo_empty = empty_r;
    assign local_fifo_full  = full_r;
    assign fifo_count       = count_r;

endmodule

// File: doc/local_event_fifo.md
LOCAL_EVENT_FIFO -- requirements
Module: local_event_fifo

Interface
REQ-001 Parameter WIDTH, default 64: event word width including parity; stored word is WIDTH-1 bits.
REQ-002 Parameter DEPTH, default 4: entries per channel FIFO; power of two, 2..16.
REQ-003 Port clk  input  1: master clock; the block uses only this one clock.
REQ-004 Port reset  input  1: reset is synchronous and active-high.
REQ-005 Port write_data  input  WIDTH-1: event word from channel digitizer (pre-parity).
REQ-006 Port write_req  input  1: high for one cycle per event to store.
REQ-007 Port read_local_fifo_n  input  1: active-low pop request from the event router.
REQ-008 Port local_event_out  output  WIDTH-1: head-of-FIFO word, first-word-fall-through.
REQ-009 Port local_fifo_empty  output  1: high when no word is stored.
REQ-010 Port local_fifo_full  output  1: high when DEPTH words are stored.
REQ-011 Port fifo_count  output  $clog2(DEPTH)+1: number of stored words.
REQ-012 Port overflow_count  output  8: saturating count of dropped writes; present only with the macro in REQ-030.

Function
REQ-013 Storage SHALL be a circular buffer with registered write pointer, read pointer and occupancy count; pointers wrap from DEPTH-1 to 0.
REQ-014 local_event_out SHALL be combinationally driven from the read-pointer entry while not empty, and SHALL be all-zero while empty.
REQ-015 A pop SHALL occur on each rising clk edge where read_local_fifo_n is low and local_fifo_empty is high-false; a pop advances the read pointer and decrements the count.
REQ-016 Pop latency: the head word SHALL be stable for the whole cycle in which read_local_fifo_n is low; the next word or the empty flag SHALL appear one cycle after the popping edge.
REQ-017 A pop request while empty SHALL have no effect on pointers, count or outputs.
REQ-018 A write SHALL occur on each edge where write_req is high and the FIFO is not full, or is full while a pop occurs on the same edge.
REQ-019 A write while full without a simultaneous pop SHALL be dropped; stored contents are unchanged.
REQ-020 Simultaneous write and pop while empty SHALL accept the write only; there is no bypass; local_fifo_empty falls one cycle later.
REQ-021 Simultaneous write and pop while non-empty SHALL leave the count unchanged.
REQ-022 local_fifo_empty, local_fifo_full and fifo_count SHALL be registered and consistent with the count after every edge.
REQ-023 A low on read_local_fifo_n for N consecutive cycles SHALL pop min(N, stored + arriving) words, one per cycle.

Reset
REQ-024 While reset is high at an edge: both pointers and the count SHALL be 0, local_fifo_empty 1, local_fifo_full 0, and overflow_count 0.
REQ-025 local_event_out SHALL read all-zero during reset and on the first cycle after reset.
REQ-026 Reset mid-operation SHALL discard all stored words, and it takes priority over a write or pop on the same edge.
REQ-027 Storage array contents need no reset.

Configuration
REQ-028 With macro LOCAL_FIFO_OVERFLOW_COUNT_EN defined, overflow_count SHALL increment on each dropped write (REQ-019) and saturate at 255.
REQ-029 With macro LOCAL_FIFO_OVERFLOW_COUNT_EN undefined, the overflow_count port and its logic SHALL be absent.
REQ-030 Macro name: LOCAL_FIFO_OVERFLOW_COUNT_EN; all other behaviour SHALL be identical with or without it.

Structure
REQ-031 The shared package SHALL hold the WIDTH and DEPTH defaults, the event-word typedef (WIDTH-1 bits) and the pointer-width constant.
REQ-032 The storage array SHALL be a sub-module named local_fifo_mem (one write port, one asynchronous read port); pointer and flag logic stay in local_event_fifo.
REQ-033 The block SHALL be instantiated 64 times, with local_event_out, local_fifo_empty and read_local_fifo_n bit i connected to router channel i.

Verification
REQ-034 Reset, then write 0x1, 0x2, 0x3 on consecutive cycles -> fifo_count 3, head 0x1, empty 0.
REQ-035 With 3 stored, hold read_local_fifo_n low for 1 cycle -> 0x1 valid during the low cycle, head 0x2 next cycle, fifo_count 2.
REQ-036 Fill to DEPTH=4, write 0xAA -> dropped, full 1, overflow_count 1 (macro on); hold pop low 4 cycles -> 0x1..0x4 out in order, then empty 1, out 0.
REQ-037 Full (count 4) with write_req and pop on the same edge -> count stays 4, new word at tail; empty FIFO with both -> count 1, no pop.
REQ-038 Assert reset with 2 words stored while writing and popping -> count 0, empty 1, out 0, overflow_count 0 next cycle.
REQ-039 Issue 300 writes while full -> overflow_count saturates at 255 (macro on); no port exists with the macro off.
